// File: rtl/ts_serial_tx_if.sv
// Byte-stream input bus for the serial TS transmitter.
// Ports/signals:
//   in_data  - packet byte
//   in_valid - in_data valid
//   in_sop   - byte is first of a packet
//   in_ready - byte accepted when in_valid && in_ready at posedge
// master: byte source, slave: transmitter.
interface ts_serial_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sop;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_sop, input in_ready);
  modport slave  (input in_data, input in_valid, input in_sop, output in_ready);
endinterface

// File: rtl/ts_serial_tx.sv
// Serial MPEG-TS transmitter: turns 188-byte packets from a valid/ready byte
// stream into a 1-bit serial TS bus (clock, data, valid, start), MSB first.
// Ports:
//   clk, reset_n  - system clock, async active-low reset
//   enable        - start new packets while high
//   in_if         - byte input bus (data/valid/sop/ready)
//   ts_clk        - serial clock, falls when ts_* change
//   ts_data       - serial data
//   ts_valid      - ts_data carries packet data
//   ts_start      - high during bit 7 of the sync byte
//   pkt_count     - packets fully sent, wraps
//   sync_err      - one-cycle pulse per discarded byte
module ts_serial_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned PKT_LEN  = 188,
  parameter int unsigned GAP_BITS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  ts_serial_tx_if.slave in_if,
  output logic          ts_clk,
  output logic          ts_data,
  output logic          ts_valid,
  output logic          ts_start,
  output logic [15:0]   pkt_count,
  output logic          sync_err
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(PKT_LEN);
  localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_nx;
  logic [DIV_W-1:0] div_q, div_nx;
  logic             tick;
  logic [7:0]       sh_q, sh_nx;
  logic [2:0]       bits_q, bits_nx;     // bits still to send from sh_q
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [GAP_W-1:0] gap_q, gap_nx;
  logic [7:0]       hold_q, hold_nx;
  logic             hold_full_q, hold_full_nx;
  logic             hold_start_q, hold_start_nx;
  logic             ready_q, ready_nx;
  logic             accept, load;
  logic             ts_clk_nx, ts_data_nx, ts_valid_nx, ts_start_nx, sync_err_nx;
  logic [15:0]      pkt_count_nx;

  assign in_if.in_ready = ready_q;
  assign accept = in_if.in_valid && ready_q;
  assign tick   = (div_q == DIV_LAST);
  assign div_nx = tick ? '0 : div_q + DIV_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (tick && hold_full_q && hold_start_q && enable) state_nx = SHIFT;
      SHIFT:   if (tick && bits_q == 3'd1 && idx_q == LAST_IDX) state_nx = GAP;
      GAP:     if (tick && gap_q == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sh_nx         = sh_q;
    bits_nx       = bits_q;
    idx_nx        = idx_q;
    gap_nx        = gap_q;
    hold_nx       = hold_q;
    hold_full_nx  = hold_full_q;
    hold_start_nx = hold_start_q;
    ts_data_nx    = ts_data;
    ts_valid_nx   = ts_valid;
    ts_start_nx   = ts_start;
    pkt_count_nx  = pkt_count;
    sync_err_nx   = 1'b0;
    load          = 1'b0;
    ts_clk_nx     = (div_nx >= DIV_HALF);

    if (tick) begin
      case (state_q)
        IDLE: begin
          ts_data_nx  = 1'b0;
          ts_valid_nx = 1'b0;
          ts_start_nx = 1'b0;
          if (state_nx == SHIFT) begin
            load        = 1'b1;
            idx_nx      = '0;
            ts_start_nx = 1'b1;
          end
        end
        SHIFT: begin
          ts_start_nx = 1'b0;
          if (bits_q != 3'd0) begin
            ts_data_nx  = sh_q[7];
            ts_valid_nx = 1'b1;
            sh_nx       = {sh_q[6:0], 1'b0};
            bits_nx     = bits_q - 3'd1;
            if (state_nx == GAP) begin
              pkt_count_nx = pkt_count + 16'd1;
              gap_nx       = '0;
            end
          end else if (hold_full_q) begin
            load   = 1'b1;
            idx_nx = idx_q + IDX_W'(1);
          end else begin
            // Underrun: idle this bit period and retry the boundary next tick
            ts_data_nx  = 1'b0;
            ts_valid_nx = 1'b0;
          end
        end
        default: begin
          ts_data_nx  = 1'b0;
          ts_valid_nx = 1'b0;
          ts_start_nx = 1'b0;
          gap_nx      = gap_q + GAP_W'(1);
        end
      endcase
    end

    // A loaded byte puts its MSB on the wire in the same tick
    if (load) begin
      ts_data_nx   = hold_q[7];
      ts_valid_nx  = 1'b1;
      sh_nx        = {hold_q[6:0], 1'b0};
      bits_nx      = 3'd7;
      hold_full_nx = 1'b0;
    end

    // A byte left over from the gap that is not a packet start is dropped in IDLE
    if (state_q == IDLE && hold_full_q && !hold_start_q) begin
      hold_full_nx = 1'b0;
      sync_err_nx  = 1'b1;
    end

    if (accept) begin
      if (state_q == IDLE && !(in_if.in_sop && in_if.in_data == 8'h47)) begin
        sync_err_nx = 1'b1;
      end else begin
        hold_nx       = in_if.in_data;
        hold_full_nx  = 1'b1;
        hold_start_nx = in_if.in_sop && (in_if.in_data == 8'h47);
      end
    end

    ready_nx = !hold_full_nx && (state_nx != IDLE || enable);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      sh_q         <= '0;
      bits_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      hold_start_q <= 1'b0;
      ready_q      <= 1'b0;
      ts_clk       <= 1'b0;
      ts_data      <= 1'b0;
      ts_valid     <= 1'b0;
      ts_start     <= 1'b0;
      pkt_count    <= '0;
      sync_err     <= 1'b0;
    end else begin
      div_q        <= div_nx;
      sh_q         <= sh_nx;
      bits_q       <= bits_nx;
      idx_q        <= idx_nx;
      gap_q        <= gap_nx;
      hold_q       <= hold_nx;
      hold_full_q  <= hold_full_nx;
      hold_start_q <= hold_start_nx;
      ready_q      <= ready_nx;
      ts_clk       <= ts_clk_nx;
      ts_data      <= ts_data_nx;
      ts_valid     <= ts_valid_nx;
      ts_start     <= ts_start_nx;
      pkt_count    <= pkt_count_nx;
      sync_err     <= sync_err_nx;
    end
  end
endmodule
